mem_bus_arbiter: RTL and testbench



---
 rtl/mem_bus_arbiter.sv | 128 ++++++++++++
 tb/tb_mem_bus_arbiter.sv | 258 +++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_bus_arbiter.sv
//------------------------------------------------------------------------------
// Module   : mem_bus_arbiter
// Function : Serialises core instruction/data requests onto a single-beat
//            memory bus and returns completions as addr_ok/data_ok pulses.
//            Optional round-robin tie-break: define ARB_FAIR_EN.
// Revision : 1.0  initial release
//------------------------------------------------------------------------------
`default_nettype none

module mem_bus_arbiter #(
   parameter int ADDR_W = 64,
   parameter int DATA_W = 64
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              ireq_valid,
   input  logic [ADDR_W-1:0] ireq_addr,
   output logic              iresp_addr_ok,
   output logic              iresp_data_ok,
   output logic [31:0]       iresp_data,
   input  logic              dreq_valid,
   input  logic [ADDR_W-1:0] dreq_addr,
   input  logic [2:0]        dreq_size,
   input  logic [7:0]        dreq_strobe,
   input  logic [DATA_W-1:0] dreq_data,
   output logic              dresp_addr_ok,
   output logic              dresp_data_ok,
   output logic [DATA_W-1:0] dresp_data,
   output logic              creq_valid,
   output logic              creq_is_write,
   output logic [2:0]        creq_size,
   output logic [ADDR_W-1:0] creq_addr,
   output logic [7:0]        creq_strobe,
   output logic [DATA_W-1:0] creq_data,
   input  logic              cresp_ready,
   input  logic [DATA_W-1:0] cresp_data
);

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      BUSY_I = 2'd1,
      BUSY_D = 2'd2
   } state_t;

   state_t r_state;
   logic   w_idle;
   logic   w_grant_d;
   logic   w_grant_i;

   // Reset gating keeps the combinational accept pulses quiet while held in reset.
   assign w_idle = (r_state == IDLE) && reset;

`ifdef ARB_FAIR_EN
   logic r_last_grant_d;
   assign w_grant_d = w_idle && dreq_valid && !(ireq_valid && r_last_grant_d);
`else
   assign w_grant_d = w_idle && dreq_valid;
`endif
   assign w_grant_i = w_idle && ireq_valid && !w_grant_d;

   assign dresp_addr_ok = w_grant_d;
   assign iresp_addr_ok = w_grant_i;

   // A master that dropped valid before completion has abandoned its response.
   assign iresp_data_ok = (r_state == BUSY_I) && cresp_ready && ireq_valid;
   assign dresp_data_ok = (r_state == BUSY_D) && cresp_ready && dreq_valid;

   assign iresp_data = iresp_data_ok ?
                       (creq_addr[2] ? cresp_data[63:32] : cresp_data[31:0]) : 32'h0;
   assign dresp_data = dresp_data_ok ? cresp_data : '0;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_state       <= IDLE;
         creq_valid    <= 1'b0;
         creq_is_write <= 1'b0;
         creq_size     <= 3'd0;
         creq_addr     <= '0;
         creq_strobe   <= 8'h0;
         creq_data     <= '0;
`ifdef ARB_FAIR_EN
         r_last_grant_d <= 1'b0;
`endif
      end else begin
         case (r_state)
            IDLE: begin
               if (w_grant_d) begin
                  r_state       <= BUSY_D;
                  creq_valid    <= 1'b1;
                  creq_is_write <= |dreq_strobe;
                  creq_size     <= dreq_size;
                  creq_addr     <= dreq_addr;
                  creq_strobe   <= dreq_strobe;
                  creq_data     <= dreq_data;
`ifdef ARB_FAIR_EN
                  r_last_grant_d <= 1'b1;
`endif
               end else if (w_grant_i) begin
                  r_state       <= BUSY_I;
                  creq_valid    <= 1'b1;
                  creq_is_write <= 1'b0;
                  creq_size     <= 3'b010;
                  creq_addr     <= ireq_addr;
                  creq_strobe   <= 8'h0;
                  creq_data     <= '0;
`ifdef ARB_FAIR_EN
                  r_last_grant_d <= 1'b0;
`endif
               end
            end
            BUSY_I, BUSY_D: begin
               // Completion ends the beat even when abandoned, so writes still land.
               if (cresp_ready) begin
                  r_state    <= IDLE;
                  creq_valid <= 1'b0;
               end
            end
            default: begin
               r_state    <= IDLE;
               creq_valid <= 1'b0;
            end
         endcase
      end
   end

endmodule

`default_nettype wire

// File: tb/tb_mem_bus_arbiter.sv
//------------------------------------------------------------------------------
// Module   : tb_mem_bus_arbiter
// Function : Self-checking bench for mem_bus_arbiter (vector table, directed
//            reset sequences, randomized traffic against a transaction model).
// Revision : 1.0  initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_mem_bus_arbiter;

`ifdef ARB_FAIR_EN
   localparam bit FAIR = 1'b1;
`else
   localparam bit FAIR = 1'b0;
`endif

   localparam logic [63:0] Z   = 64'h0;
   localparam logic [63:0] A4  = 64'h8000_0004;
   localparam logic [63:0] A0  = 64'h8000_0000;
   localparam logic [63:0] D1  = 64'h8000_1000;
   localparam logic [63:0] W   = 64'h8000_2004;
   localparam logic [63:0] WD  = 64'hDEAD_BEEF_0000_0000;
   localparam logic [63:0] AB  = 64'h8000_3000;
   localparam logic [63:0] CD  = 64'h1122_3344_5566_7788;
   localparam logic [63:0] CD2 = 64'h0102_0304_0506_0708;

   logic        clk = 1'b0;
   logic        reset;
   logic        ireq_valid;
   logic [63:0] ireq_addr;
   logic        iresp_addr_ok, iresp_data_ok;
   logic [31:0] iresp_data;
   logic        dreq_valid;
   logic [63:0] dreq_addr;
   logic [2:0]  dreq_size;
   logic [7:0]  dreq_strobe;
   logic [63:0] dreq_data;
   logic        dresp_addr_ok, dresp_data_ok;
   logic [63:0] dresp_data;
   logic        creq_valid, creq_is_write;
   logic [2:0]  creq_size;
   logic [63:0] creq_addr;
   logic [7:0]  creq_strobe;
   logic [63:0] creq_data;
   logic        cresp_ready;
   logic [63:0] cresp_data;

   int nvec = 0;
   int nerr = 0;

   always #5 clk = ~clk;

   mem_bus_arbiter #(.ADDR_W(64), .DATA_W(64)) dut (
      .clk(clk), .reset(reset),
      .ireq_valid(ireq_valid), .ireq_addr(ireq_addr),
      .iresp_addr_ok(iresp_addr_ok), .iresp_data_ok(iresp_data_ok), .iresp_data(iresp_data),
      .dreq_valid(dreq_valid), .dreq_addr(dreq_addr), .dreq_size(dreq_size),
      .dreq_strobe(dreq_strobe), .dreq_data(dreq_data),
      .dresp_addr_ok(dresp_addr_ok), .dresp_data_ok(dresp_data_ok), .dresp_data(dresp_data),
      .creq_valid(creq_valid), .creq_is_write(creq_is_write), .creq_size(creq_size),
      .creq_addr(creq_addr), .creq_strobe(creq_strobe), .creq_data(creq_data),
      .cresp_ready(cresp_ready), .cresp_data(cresp_data)
   );

   typedef struct {
      bit          iv;
      logic [63:0] ia;
      bit          dv;
      logic [63:0] da;
      logic [2:0]  ds;
      logic [7:0]  dst;
      logic [63:0] dd;
      bit          cr;
      logic [63:0] cd;
      bit          e_iaok;
      bit          e_idok;
      logic [31:0] e_idata;
      bit          e_daok;
      bit          e_ddok;
      logic [63:0] e_ddata;
      bit          e_cv;
      bit          e_cwr;
      logic [2:0]  e_csz;
      logic [63:0] e_caddr;
      logic [7:0]  e_cstb;
      logic [63:0] e_cdata;
   } vec_t;

   vec_t tbl[$];

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      nvec++;
      if (act !== exp) begin
         nerr++;
         $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
      end
   endtask

   task automatic drive(input bit iv, input logic [63:0] ia, input bit dv, input logic [63:0] da,
                        input logic [2:0] ds, input logic [7:0] dst, input logic [63:0] dd,
                        input bit cr, input logic [63:0] cd);
      ireq_valid = iv;  ireq_addr = ia;
      dreq_valid = dv;  dreq_addr = da; dreq_size = ds; dreq_strobe = dst; dreq_data = dd;
      cresp_ready = cr; cresp_data = cd;
   endtask

   // Transaction-level reference: who owns the bus and what was accepted.
   int          m_own;     // 0 = free, 1 = fetch, 2 = data
   logic [63:0] m_addr, m_data;
   logic [2:0]  m_size;
   logic [7:0]  m_stb;
   bit          m_last_d;

   task automatic model_check_and_step();
      bit gd, gi, done, idok, ddok;
      gd = 0; gi = 0;
      if (m_own == 0) begin
         gd = dreq_valid && !(FAIR && ireq_valid && m_last_d);
         gi = ireq_valid && !gd;
      end
      done = (m_own != 0) && cresp_ready;
      idok = done && (m_own == 1) && ireq_valid;
      ddok = done && (m_own == 2) && dreq_valid;
      chk("rnd_iaok", iresp_addr_ok, gi);
      chk("rnd_daok", dresp_addr_ok, gd);
      chk("rnd_idok", iresp_data_ok, idok);
      chk("rnd_ddok", dresp_data_ok, ddok);
      chk("rnd_idata", iresp_data, idok ? (m_addr[2] ? cresp_data[63:32] : cresp_data[31:0]) : 0);
      chk("rnd_ddata", dresp_data, ddok ? cresp_data : 0);
      chk("rnd_cv", creq_valid, m_own != 0);
      if (m_own != 0) begin
         chk("rnd_caddr", creq_addr, m_addr);
         chk("rnd_csize", creq_size, (m_own == 1) ? 64'd2 : 64'(m_size));
         chk("rnd_cstb", creq_strobe, (m_own == 1) ? 64'd0 : 64'(m_stb));
         chk("rnd_cwr", creq_is_write, (m_own == 2) && (m_stb != 0));
         if (m_own == 2 && m_stb != 0) chk("rnd_cdata", creq_data, m_data);
      end
      if (gd) begin
         m_own = 2; m_addr = dreq_addr; m_size = dreq_size; m_stb = dreq_strobe;
         m_data = dreq_data; m_last_d = 1;
      end else if (gi) begin
         m_own = 1; m_addr = ireq_addr; m_last_d = 0;
      end else if (done) begin
         m_own = 0;
      end
   endtask

   initial begin
      // Columns: iv ia dv da ds dst dd cr cd | iaok idok idata daok ddok ddata cv cwr csz caddr cstb cdata
      tbl.push_back('{1,A4,0,Z,0,0,Z,0,Z,   1,0,0,0,0,Z,   0,0,0,Z,0,Z});
      tbl.push_back('{1,A4,0,Z,0,0,Z,0,Z,   0,0,0,0,0,Z,   1,0,2,A4,0,Z});
      tbl.push_back('{1,A4,0,Z,0,0,Z,0,Z,   0,0,0,0,0,Z,   1,0,2,A4,0,Z});
      tbl.push_back('{1,A4,0,Z,0,0,Z,1,CD,  0,1,32'h11223344,0,0,Z, 1,0,2,A4,0,Z});
      tbl.push_back('{0,Z,0,Z,0,0,Z,0,Z,    0,0,0,0,0,Z,   0,0,0,Z,0,Z});
      tbl.push_back('{1,A0,0,Z,0,0,Z,0,Z,   1,0,0,0,0,Z,   0,0,0,Z,0,Z});
      tbl.push_back('{1,A0,0,Z,0,0,Z,1,CD,  0,1,32'h55667788,0,0,Z, 1,0,2,A0,0,Z});
      tbl.push_back('{0,Z,0,Z,0,0,Z,0,Z,    0,0,0,0,0,Z,   0,0,0,Z,0,Z});
      tbl.push_back('{1,A0,1,D1,3,0,Z,0,Z,  0,0,0,1,0,Z,   0,0,0,Z,0,Z});
      tbl.push_back('{1,A0,1,D1,3,0,Z,1,CD2, 0,0,0,0,1,CD2, 1,0,3,D1,0,Z});
      tbl.push_back('{1,A0,0,Z,0,0,Z,0,Z,   1,0,0,0,0,Z,   0,0,0,Z,0,Z});
      tbl.push_back('{1,A0,0,Z,0,0,Z,1,CD,  0,1,32'h55667788,0,0,Z, 1,0,2,A0,0,Z});
      tbl.push_back('{0,Z,0,Z,0,0,Z,0,Z,    0,0,0,0,0,Z,   0,0,0,Z,0,Z});
      tbl.push_back('{0,Z,1,W,2,8'hF0,WD,0,Z, 0,0,0,1,0,Z, 0,0,0,Z,0,Z});
      tbl.push_back('{0,Z,1,W,2,8'hF0,WD,0,Z, 0,0,0,0,0,Z, 1,1,2,W,8'hF0,WD});
      tbl.push_back('{0,Z,1,W,2,8'hF0,WD,1,64'hFFFF, 0,0,0,0,1,64'hFFFF, 1,1,2,W,8'hF0,WD});
      tbl.push_back('{0,Z,1,AB,3,8'h0F,64'h1234,0,Z, 0,0,0,1,0,Z, 0,0,0,Z,0,Z});
      tbl.push_back('{1,A0,0,AB,3,8'h0F,64'h1234,0,Z, 0,0,0,0,0,Z, 1,1,3,AB,8'h0F,64'h1234});
      tbl.push_back('{1,A0,0,AB,3,8'h0F,64'h1234,1,64'hAAAA, 0,0,0,0,0,Z, 1,1,3,AB,8'h0F,64'h1234});
      tbl.push_back('{1,A0,0,Z,0,0,Z,0,Z,   1,0,0,0,0,Z,   0,0,0,Z,0,Z});
      tbl.push_back('{1,A0,0,Z,0,0,Z,1,CD,  0,1,32'h55667788,0,0,Z, 1,0,2,A0,0,Z});
      tbl.push_back('{0,Z,1,D1,3,0,Z,0,Z,   0,0,0,1,0,Z,   0,0,0,Z,0,Z});
      tbl.push_back('{1,A0,1,D1,3,0,Z,1,CD2, 0,0,0,0,1,CD2, 1,0,3,D1,0,Z});
      tbl.push_back('{1,A0,1,D1,3,0,Z,0,Z,  FAIR,0,0,!FAIR,0,Z, 0,0,0,Z,0,Z});
      tbl.push_back('{1,A0,1,D1,3,0,Z,1,CD, 0,FAIR,(FAIR ? 32'h55667788 : 32'h0),0,!FAIR,(FAIR ? Z : CD),
                      1,0,(FAIR ? 3'd2 : 3'd3),(FAIR ? A0 : D1),0,Z});
      tbl.push_back('{0,Z,0,Z,0,0,Z,1,CD,   0,0,0,0,0,Z,   0,0,0,Z,0,Z});
      tbl.push_back('{0,Z,0,Z,0,0,Z,0,Z,    0,0,0,0,0,Z,   0,0,0,Z,0,Z});

      // Reset held with both masters requesting.
      reset = 1'b0;
      drive(1, A0, 1, 64'h8000_5000, 3, 0, Z, 0, Z);
      for (int c = 0; c < 3; c++) begin
         @(negedge clk); #1;
         chk("rst_cv", creq_valid, 0);
         chk("rst_oks", {iresp_addr_ok, iresp_data_ok, dresp_addr_ok, dresp_data_ok}, 0);
         chk("rst_creq", {creq_is_write, creq_size, creq_strobe}, 0);
         chk("rst_caddr", creq_addr, 0);
         chk("rst_cdata", creq_data, 0);
      end
      @(negedge clk);
      reset = 1'b1; #1;
      chk("rel_daok", dresp_addr_ok, 1);
      chk("rel_iaok", iresp_addr_ok, 0);
      @(negedge clk);
      drive(1, A0, 1, 64'h8000_5000, 3, 0, Z, 1, 64'h5555); #1;
      chk("rel_cv", creq_valid, 1);
      chk("rel_caddr", creq_addr, 64'h8000_5000);
      chk("rel_ddok", dresp_data_ok, 1);
      chk("rel_ddata", dresp_data, 64'h5555);
      @(negedge clk);
      drive(0, Z, 0, Z, 0, 0, Z, 0, Z); #1;
      chk("rel_bubble", creq_valid, 0);

      foreach (tbl[i]) begin
         @(negedge clk);
         drive(tbl[i].iv, tbl[i].ia, tbl[i].dv, tbl[i].da, tbl[i].ds, tbl[i].dst, tbl[i].dd,
               tbl[i].cr, tbl[i].cd);
         #1;
         chk($sformatf("v%0d_iaok", i), iresp_addr_ok, tbl[i].e_iaok);
         chk($sformatf("v%0d_idok", i), iresp_data_ok, tbl[i].e_idok);
         chk($sformatf("v%0d_idata", i), iresp_data, tbl[i].e_idata);
         chk($sformatf("v%0d_daok", i), dresp_addr_ok, tbl[i].e_daok);
         chk($sformatf("v%0d_ddok", i), dresp_data_ok, tbl[i].e_ddok);
         chk($sformatf("v%0d_ddata", i), dresp_data, tbl[i].e_ddata);
         chk($sformatf("v%0d_cv", i), creq_valid, tbl[i].e_cv);
         if (tbl[i].e_cv) begin
            chk($sformatf("v%0d_cwr", i), creq_is_write, tbl[i].e_cwr);
            chk($sformatf("v%0d_csz", i), creq_size, tbl[i].e_csz);
            chk($sformatf("v%0d_caddr", i), creq_addr, tbl[i].e_caddr);
            chk($sformatf("v%0d_cstb", i), creq_strobe, tbl[i].e_cstb);
            if (tbl[i].e_cwr) chk($sformatf("v%0d_cdata", i), creq_data, tbl[i].e_cdata);
         end
      end

      // Asynchronous reset in the middle of a fetch.
      @(negedge clk);
      drive(1, A4, 0, Z, 0, 0, Z, 0, Z); #1;
      chk("ar_iaok", iresp_addr_ok, 1);
      @(negedge clk); #1;
      chk("ar_cv_busy", creq_valid, 1);
      #2 reset = 1'b0;
      #1 chk("ar_cv_async", creq_valid, 0);
      @(negedge clk); #1;
      chk("ar_cv_held", creq_valid, 0);
      reset = 1'b1;
      drive(1, A4, 0, Z, 0, 0, Z, 1, CD); #1;
      chk("ar_idok", iresp_data_ok, 0);
      chk("ar_cv_rel", creq_valid, 0);
      chk("ar_regrant", iresp_addr_ok, 1);
      m_own = 1; m_addr = A4; m_last_d = 0; m_size = 0; m_stb = 0; m_data = 0;

      for (int c = 0; c < 2000; c++) begin
         @(negedge clk);
         drive($urandom_range(0, 9) < 6, {$urandom, $urandom} & ~64'h3,
               $urandom_range(0, 9) < 5, {$urandom, $urandom}, 3'($urandom_range(0, 3)),
               ($urandom_range(0, 1) == 1) ? 8'($urandom) : 8'h0, {$urandom, $urandom},
               $urandom_range(0, 2) == 0, {$urandom, $urandom});
         #1;
         model_check_and_step();
      end

      $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
      $finish;
   end

endmodule

`default_nettype wire
